// File: rtl/csr_rmw_ctrl.sv
// ============================================================================
// csr_rmw_ctrl : multi-cycle read-modify-write sequencer for CSRRW/S/C(I).
// Revision 1.0
// ============================================================================
`default_nettype none

module csr_rmw_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_zimm,
  input  logic            req_rs1_is_x0,
  input  logic            req_rd_is_x0,
  output logic            csr_rd_en,
  output logic [11:0]     csr_rd_addr,
  input  logic [XLEN-1:0] csr_rd_data,
  input  logic            csr_rd_valid,
  input  logic            csr_rd_err,
  output logic            csr_wr_en,
  output logic [11:0]     csr_wr_addr,
  output logic [XLEN-1:0] csr_wr_data,
  input  logic            csr_wr_ready,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rd_data,
  output logic            resp_illegal
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [11:0]       addr_q, addr_d;
  logic [XLEN-1:0]   src_q, src_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic              wr_need_q, wr_need_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [XLEN-1:0]   w_src;
  logic              w_is_rw;
  logic              w_wr_need;
  logic              w_rd_need;
  logic              w_expired;

  assign w_src     = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_zimm} : req_rs1_val;
  assign w_is_rw   = (req_funct3[1:0] == OP_RW);
  assign w_wr_need = w_is_rw || !req_rs1_is_x0;
  assign w_rd_need = !(w_is_rw && req_rd_is_x0);
  assign w_expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      addr_q    <= 12'h000;
      src_q     <= '0;
      old_q     <= '0;
      wr_need_q <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      src_q     <= src_d;
      old_q     <= old_d;
      wr_need_q <= wr_need_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    src_d     = src_q;
    old_d     = old_q;
    wr_need_d = wr_need_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_funct3[1:0];
          addr_d    = req_addr;
          src_d     = w_src;
          wr_need_d = w_wr_need;
          old_d     = '0;
          illegal_d = 1'b0;
          cnt_d     = '0;
          // Top two address bits 11 mark a read-only CSR.
          if (req_funct3[1:0] == 2'b00 || (w_wr_need && req_addr[11:10] == 2'b11)) begin
            illegal_d = 1'b1;
            state_d   = S_RESP;
          end else if (w_rd_need) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_READ: begin
        if (csr_rd_valid) begin
          cnt_d = '0;
          if (csr_rd_err) begin
            illegal_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            old_d   = csr_rd_data;
            state_d = wr_need_q ? S_WRITE : S_RESP;
          end
        end else if (w_expired) begin
          illegal_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (csr_wr_ready) begin
          state_d = S_RESP;
        end else if (w_expired) begin
          illegal_d = 1'b1;
          old_d     = '0;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready   = (state_q == S_IDLE);
  assign csr_rd_en   = (state_q == S_READ);
  assign csr_wr_en   = (state_q == S_WRITE);
  assign resp_valid  = (state_q == S_RESP);
  assign csr_rd_addr = csr_rd_en ? addr_q : 12'h000;
  assign csr_wr_addr = csr_wr_en ? addr_q : 12'h000;

  always_comb begin
    csr_wr_data = '0;
    if (csr_wr_en) begin
      case (op_q)
        OP_RS:   csr_wr_data = old_q | src_q;
        OP_RC:   csr_wr_data = old_q & ~src_q;
        default: csr_wr_data = src_q;
      endcase
    end
  end

  // old_q is forced to zero on every illegal path, so no extra masking here.
  assign resp_rd_data = resp_valid ? old_q : '0;
  assign resp_illegal = resp_valid & illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_rmw_ctrl.sv
// ============================================================================
// tb_csr_rmw_ctrl : directed self-checking bench for csr_rmw_ctrl.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_csr_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'b000;
  logic [11:0] req_addr = 12'h000;
  logic [31:0] req_rs1_val = 32'h0;
  logic [4:0]  req_zimm = 5'h0;
  logic        req_rs1_is_x0 = 1'b0;
  logic        req_rd_is_x0 = 1'b0;
  logic        csr_rd_en;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_rd_valid;
  logic        csr_rd_err;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        csr_wr_ready;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rd_data;
  logic        resp_illegal;

  // CSR-file stand-in: zero-wait responses gated by per-test knobs.
  logic        r_rd_ok = 1'b1;
  logic        r_wr_ok = 1'b1;
  logic        r_rd_err = 1'b0;
  logic [31:0] r_csr_val = 32'h0;

  assign csr_rd_valid = csr_rd_en & r_rd_ok;
  assign csr_rd_err   = r_rd_err;
  assign csr_rd_data  = r_csr_val;
  assign csr_wr_ready = csr_wr_en & r_wr_ok;

  always #5 clk = ~clk;

  csr_rmw_ctrl #(.XLEN(32), .TIMEOUT(16)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_rs1_val  (req_rs1_val),
    .req_zimm     (req_zimm),
    .req_rs1_is_x0(req_rs1_is_x0),
    .req_rd_is_x0 (req_rd_is_x0),
    .csr_rd_en    (csr_rd_en),
    .csr_rd_addr  (csr_rd_addr),
    .csr_rd_data  (csr_rd_data),
    .csr_rd_valid (csr_rd_valid),
    .csr_rd_err   (csr_rd_err),
    .csr_wr_en    (csr_wr_en),
    .csr_wr_addr  (csr_wr_addr),
    .csr_wr_data  (csr_wr_data),
    .csr_wr_ready (csr_wr_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rd_data (resp_rd_data),
    .resp_illegal (resp_illegal)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Per-operation observations, filled by run_op.
  int          o_rd_cyc, o_wr_cyc, o_resp_cyc, o_rd_n, o_wr_n, o_both;
  logic [31:0] o_wr_data, o_rd_data;
  logic [11:0] o_rd_addr, o_wr_addr;
  logic        o_illegal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op; returns one cycle after acceptance (cycle 1).
  task automatic start_op(input logic [2:0] f3, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic [4:0] zimm,
                          input logic rs1x0, input logic rdx0);
    req_funct3    = f3;
    req_addr      = addr;
    req_rs1_val   = rs1;
    req_zimm      = zimm;
    req_rs1_is_x0 = rs1x0;
    req_rd_is_x0  = rdx0;
    req_valid     = 1'b1;
    tick();
    req_valid     = 1'b0;
  endtask

  // Run an op until resp_valid is seen (bounded), recording port activity per cycle.
  task automatic run_op(input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [4:0] zimm,
                        input logic rs1x0, input logic rdx0);
    o_rd_cyc = -1; o_wr_cyc = -1; o_resp_cyc = -1;
    o_rd_n = 0; o_wr_n = 0; o_both = 0;
    o_wr_data = 32'h0; o_rd_data = 32'h0; o_illegal = 1'b0;
    o_rd_addr = 12'h0; o_wr_addr = 12'h0;
    start_op(f3, addr, rs1, zimm, rs1x0, rdx0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (csr_rd_en && csr_wr_en) o_both++;
      if (csr_rd_en) begin
        o_rd_n++;
        if (o_rd_cyc < 0) begin o_rd_cyc = cyc; o_rd_addr = csr_rd_addr; end
      end
      if (csr_wr_en) begin
        o_wr_n++;
        if (o_wr_cyc < 0) begin
          o_wr_cyc = cyc; o_wr_data = csr_wr_data; o_wr_addr = csr_wr_addr;
        end
      end
      if (resp_valid) begin
        o_resp_cyc = cyc; o_rd_data = resp_rd_data; o_illegal = resp_illegal;
        break;
      end
      tick();
    end
    check("resp_seen", 32'(o_resp_cyc >= 0), 32'h1);
  endtask

  task automatic finish_op();
    tick();
    check("req_ready_after", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    int wr_seen;

    // Reset state
    #12;
    check("rst_req_ready",  {31'h0, req_ready},  32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rd_en",      {31'h0, csr_rd_en},  32'h0);
    check("rst_wr_en",      {31'h0, csr_wr_en},  32'h0);
    check("rst_rd_data",    resp_rd_data,        32'h0);
    rst = 1'b0;
    tick();

    // CSRRS 0x300 rs1=0x8, CSR=0x1: old|src = 0x9
    r_csr_val = 32'h1;
    run_op(3'b010, 12'h300, 32'h8, 5'h0, 1'b0, 1'b0);
    check("rs_rd_cyc",   32'(o_rd_cyc),   32'd1);
    check("rs_rd_addr",  {20'h0, o_rd_addr}, 32'h300);
    check("rs_wr_cyc",   32'(o_wr_cyc),   32'd2);
    check("rs_wr_addr",  {20'h0, o_wr_addr}, 32'h300);
    check("rs_wr_data",  o_wr_data,       32'h9);
    check("rs_resp_cyc", 32'(o_resp_cyc), 32'd3);
    check("rs_rd_data",  o_rd_data,       32'h1);
    check("rs_illegal",  {31'h0, o_illegal}, 32'h0);
    check("rs_exclusive", 32'(o_both),    32'd0);
    finish_op();

    // CSRRCI zimm=3, CSR=0xF: 0xF & ~0x3 = 0xC
    r_csr_val = 32'hF;
    run_op(3'b111, 12'h340, 32'hFFFF_FFFF, 5'h3, 1'b0, 1'b0);
    check("rci_wr_data", o_wr_data, 32'hC);
    check("rci_rd_data", o_rd_data, 32'hF);
    finish_op();

    // CSRRSI zimm=0: read only, no write
    r_csr_val = 32'h55;
    run_op(3'b110, 12'h300, 32'h0, 5'h0, 1'b1, 1'b0);
    check("rsi0_wr_n",     32'(o_wr_n),     32'd0);
    check("rsi0_rd_data",  o_rd_data,       32'h55);
    check("rsi0_resp_cyc", 32'(o_resp_cyc), 32'd2);
    finish_op();

    // CSRRW rd=x0: write only, old reported as 0
    r_csr_val = 32'h1234;
    run_op(3'b001, 12'h305, 32'hABCD, 5'h0, 1'b0, 1'b1);
    check("rw0_rd_n",     32'(o_rd_n),     32'd0);
    check("rw0_wr_cyc",   32'(o_wr_cyc),   32'd1);
    check("rw0_wr_data",  o_wr_data,       32'hABCD);
    check("rw0_rd_data",  o_rd_data,       32'h0);
    check("rw0_resp_cyc", 32'(o_resp_cyc), 32'd2);
    finish_op();

    // CSRRW to read-only 0xC00: illegal at c1, no port activity
    run_op(3'b001, 12'hC00, 32'h5, 5'h0, 1'b0, 1'b0);
    check("ro_rd_n",     32'(o_rd_n + o_wr_n), 32'd0);
    check("ro_illegal",  {31'h0, o_illegal},   32'h1);
    check("ro_resp_cyc", 32'(o_resp_cyc),      32'd1);
    check("ro_rd_data",  o_rd_data,            32'h0);
    finish_op();

    // funct3 op field 00 is invalid
    run_op(3'b000, 12'h300, 32'h5, 5'h0, 1'b0, 1'b0);
    check("op0_ports",    32'(o_rd_n + o_wr_n), 32'd0);
    check("op0_illegal",  {31'h0, o_illegal},   32'h1);
    check("op0_resp_cyc", 32'(o_resp_cyc),      32'd1);
    finish_op();

    // CSRRS 0xC00 rs1=x0 is a legal read
    r_csr_val = 32'h1234;
    run_op(3'b010, 12'hC00, 32'h0, 5'h0, 1'b1, 1'b0);
    check("roread_illegal", {31'h0, o_illegal}, 32'h0);
    check("roread_rd_data", o_rd_data,          32'h1234);
    check("roread_wr_n",    32'(o_wr_n),        32'd0);
    finish_op();

    // Read timeout: rd_en high for exactly TIMEOUT cycles
    r_rd_ok = 1'b0;
    run_op(3'b010, 12'h300, 32'h8, 5'h0, 1'b0, 1'b0);
    check("to_rd_n",     32'(o_rd_n),       32'd16);
    check("to_resp_cyc", 32'(o_resp_cyc),   32'd17);
    check("to_illegal",  {31'h0, o_illegal}, 32'h1);
    check("to_rd_data",  o_rd_data,         32'h0);
    check("to_wr_n",     32'(o_wr_n),       32'd0);
    finish_op();
    r_rd_ok = 1'b1;

    // Read error: illegal, no write
    r_rd_err = 1'b1;
    r_csr_val = 32'hDEAD;
    run_op(3'b001, 12'h7C0, 32'h1, 5'h0, 1'b0, 1'b0);
    check("err_illegal", {31'h0, o_illegal}, 32'h1);
    check("err_wr_n",    32'(o_wr_n),       32'd0);
    check("err_rd_data", o_rd_data,         32'h0);
    finish_op();
    r_rd_err = 1'b0;

    // Response back-pressure: outputs hold while resp_ready is low
    resp_ready = 1'b0;
    r_csr_val  = 32'h11;
    run_op(3'b001, 12'h340, 32'h77, 5'h0, 1'b0, 1'b0);
    check("bp_wr_data", o_wr_data, 32'h77);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
      check("bp_rd_data",    resp_rd_data,        32'h11);
      check("bp_req_ready",  {31'h0, req_ready},  32'h0);
    end
    resp_ready = 1'b1;
    finish_op();

    // Async reset in WRITE while the write is stalled
    r_wr_ok = 1'b0;
    start_op(3'b001, 12'h340, 32'h99, 5'h0, 1'b0, 1'b1);
    check("rstw_wr_en_before", {31'h0, csr_wr_en}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rstw_wr_en",     {31'h0, csr_wr_en},  32'h0);
    check("rstw_wr_data",   csr_wr_data,         32'h0);
    check("rstw_req_ready", {31'h0, req_ready},  32'h1);
    tick();
    rst = 1'b0;
    r_wr_ok = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (csr_wr_en || csr_rd_en || resp_valid) wr_seen++;
    end
    check("rstw_no_activity", 32'(wr_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
